fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequential instruction fetch front end.
//   Walks a program counter from start_addr through LAST_ADDR. It reads a
//   combinational 32 x 32 instruction memory and presents each word to decode
//   through a registered valid/ready output slot. Branch redirects and halts
//   can interrupt the walk.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, start_addr      begin fetching at start_addr (taken only when idle)
//   mem_addr, mem_instr    instruction memory address / returned word
//   out_instr, out_pc      registered instruction and its address
//   out_valid, out_ready   output handshake (transfer on valid && ready)
//   br_valid, br_target    one-cycle redirect request
//   halt_req               abort fetching, return to idle without done
//   busy                   high while fetching or draining
//   done                   one-cycle pulse after the final word is accepted
module fetch_ctrl #(
    parameter int unsigned LAST_ADDR = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  start_addr,
    output logic [4:0]  mem_addr,
    input  logic [31:0] mem_instr,
    output logic [31:0] out_instr,
    output logic [4:0]  out_pc,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        br_valid,
    input  logic [4:0]  br_target,
    input  logic        halt_req,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [4:0] LAST = 5'(LAST_ADDR);

    state_t      state, state_n;
    logic [4:0]  pc, pc_n;
    logic [31:0] instr_n;
    logic [4:0]  opc_n;
    logic        valid_n;
    logic        done_n;
    logic        xfer;

    assign xfer     = out_valid && out_ready;
    assign mem_addr = pc;
    assign busy     = (state == RUN) || (state == DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= '0;
            out_instr <= '0;
            out_pc    <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            out_instr <= instr_n;
            out_pc    <= opc_n;
            out_valid <= valid_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = out_instr;
        opc_n   = out_pc;
        valid_n = out_valid;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    pc_n    = start_addr;
                    state_n = RUN;
                end
            end
            RUN, DRAIN: begin
                if (halt_req) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end else if (br_valid) begin
                    // Any held word is dropped; a word transferring this cycle
                    // has already been taken by decode.
                    valid_n = 1'b0;
                    pc_n    = br_target;
                    state_n = RUN;
                end else if (state == RUN) begin
                    if (!out_valid || out_ready) begin
                        instr_n = mem_instr;
                        opc_n   = pc;
                        valid_n = 1'b1;
                        pc_n    = pc + 5'd1;
                        if (pc == LAST) begin
                            state_n = DRAIN;
                        end
                    end
                end else if (xfer) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: LAST_ADDR = 4
    logic        rst_n_a, start_a, ready_a, br_a, halt_a;
    logic [4:0]  sa_a, bt_a, mem_addr_a, out_pc_a;
    logic [31:0] mem_instr_a, out_instr_a;
    logic        out_valid_a, busy_a, done_a;

    // Instance B: LAST_ADDR = 31
    logic        rst_n_b, start_b, ready_b, br_b, halt_b;
    logic [4:0]  sa_b, bt_b, mem_addr_b, out_pc_b;
    logic [31:0] mem_instr_b, out_instr_b;
    logic        out_valid_b, busy_b, done_b;

    int tests = 0;
    int failed = 0;

    // Memory contents: word(a) = {8'h00, (a+1)*8'h11, 16'(a)}; words 0..4 match
    // 0x00110000, 0x00220001, 0x00330002, 0x00440003, 0x00550004.
    function automatic logic [31:0] word(input logic [4:0] a);
        logic [7:0] b;
        b = 8'(({3'b000, a} + 8'd1) * 8'h11);
        return {8'h00, b, 11'd0, a};
    endfunction

    assign mem_instr_a = word(mem_addr_a);
    assign mem_instr_b = word(mem_addr_b);

    fetch_ctrl #(.LAST_ADDR(4)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a), .start_addr(sa_a),
        .mem_addr(mem_addr_a), .mem_instr(mem_instr_a),
        .out_instr(out_instr_a), .out_pc(out_pc_a), .out_valid(out_valid_a),
        .out_ready(ready_a), .br_valid(br_a), .br_target(bt_a),
        .halt_req(halt_a), .busy(busy_a), .done(done_a)
    );

    fetch_ctrl #(.LAST_ADDR(31)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b), .start_addr(sa_b),
        .mem_addr(mem_addr_b), .mem_instr(mem_instr_b),
        .out_instr(out_instr_b), .out_pc(out_pc_b), .out_valid(out_valid_b),
        .out_ready(ready_b), .br_valid(br_b), .br_target(bt_b),
        .halt_req(halt_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        logic       start;
        logic [4:0] sa;
        logic       ready;
        logic       br;
        logic [4:0] bt;
        logic       halt;
        logic       e_valid;
        logic [4:0] e_pc;
        logic [4:0] e_mem;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic st, input logic [4:0] sa, input logic rdy,
                       input logic br, input logic [4:0] bt, input logic halt,
                       input logic ev, input logic [4:0] epc, input logic [4:0] emem,
                       input logic eb, input logic ed);
        vec_t v;
        v.start = st; v.sa = sa; v.ready = rdy; v.br = br; v.bt = bt; v.halt = halt;
        v.e_valid = ev; v.e_pc = epc; v.e_mem = emem; v.e_busy = eb; v.e_done = ed;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        // Each vector: inputs held for one cycle, expectations are the
        // outputs seen just after that cycle's rising edge.
        //   st sa  rdy br bt  halt  ev pc mem busy done
        // Straight run 0..4, done pulse
        add(1, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 1, 2, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 2, 3, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 3, 4, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 4, 5, 1, 0);
        add(0, 0, 1, 0, 0, 0,  0, 4, 5, 0, 1);
        add(0, 0, 1, 0, 0, 0,  0, 4, 5, 0, 0);
        // Backpressure for 3 cycles while out_pc = 2
        add(1, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 1, 2, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 2, 3, 1, 0);
        add(0, 0, 0, 0, 0, 0,  1, 2, 3, 1, 0);
        add(0, 0, 0, 0, 0, 0,  1, 2, 3, 1, 0);
        add(0, 0, 0, 0, 0, 0,  1, 2, 3, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 3, 4, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 4, 5, 1, 0);
        add(0, 0, 0, 0, 0, 0,  1, 4, 5, 1, 0);
        add(0, 0, 1, 0, 0, 0,  0, 4, 5, 0, 1);
        add(0, 0, 1, 0, 0, 0,  0, 4, 5, 0, 0);
        // Branch to 0 while out_pc = 3 is held
        add(1, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 1, 2, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 2, 3, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 3, 4, 1, 0);
        add(0, 0, 0, 1, 0, 0,  0, 3, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 1, 2, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 2, 3, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 3, 4, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 4, 5, 1, 0);
        // Halt in DRAIN: no done; restart at 2; halt in RUN
        add(0, 0, 0, 0, 0, 1,  0, 4, 5, 0, 0);
        add(0, 0, 1, 0, 0, 0,  0, 4, 5, 0, 0);
        add(1, 2, 1, 0, 0, 0,  0, 4, 2, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 2, 3, 1, 0);
        add(0, 0, 1, 0, 0, 1,  0, 2, 3, 0, 0);
        add(0, 0, 1, 0, 0, 0,  0, 2, 3, 0, 0);
        // Priority halt > branch; branch ignored in IDLE; branch to LAST_ADDR
        add(1, 1, 1, 0, 0, 0,  0, 2, 1, 1, 0);
        add(0, 0, 1, 1, 4, 1,  0, 2, 1, 0, 0);
        add(0, 0, 1, 1, 3, 0,  0, 2, 1, 0, 0);
        add(1, 1, 1, 1, 3, 0,  0, 2, 1, 1, 0);
        add(0, 0, 1, 1, 4, 0,  0, 2, 4, 1, 0);
        add(0, 0, 1, 0, 0, 0,  1, 4, 5, 1, 0);
        add(1, 0, 0, 0, 0, 0,  1, 4, 5, 1, 0);
        add(0, 0, 1, 0, 0, 0,  0, 4, 5, 0, 1);
        add(0, 0, 1, 0, 0, 0,  0, 4, 5, 0, 0);

        rst_n_a = 1'b0; rst_n_b = 1'b0;
        start_a = 0; sa_a = 0; ready_a = 0; br_a = 0; bt_a = 0; halt_a = 0;
        start_b = 0; sa_b = 0; ready_b = 0; br_b = 0; bt_b = 0; halt_b = 0;
        #12;
        chk("rst valid", 32'(out_valid_a), 0);
        chk("rst busy", 32'(busy_a), 0);
        chk("rst done", 32'(done_a), 0);
        chk("rst mem_addr", 32'(mem_addr_a), 0);
        chk("rst out_pc", 32'(out_pc_a), 0);
        chk("rst out_instr", out_instr_a, 0);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        @(posedge clk); #1;
        chk("idle after rst", 32'(busy_a), 0);

        for (int i = 0; i < vt.size(); i++) begin
            start_a = vt[i].start; sa_a = vt[i].sa; ready_a = vt[i].ready;
            br_a = vt[i].br; bt_a = vt[i].bt; halt_a = vt[i].halt;
            @(posedge clk); #1;
            chk($sformatf("v%0d valid", i), 32'(out_valid_a), 32'(vt[i].e_valid));
            chk($sformatf("v%0d mem_addr", i), 32'(mem_addr_a), 32'(vt[i].e_mem));
            chk($sformatf("v%0d busy", i), 32'(busy_a), 32'(vt[i].e_busy));
            chk($sformatf("v%0d done", i), 32'(done_a), 32'(vt[i].e_done));
            if (vt[i].e_valid) begin
                chk($sformatf("v%0d out_pc", i), 32'(out_pc_a), 32'(vt[i].e_pc));
                chk($sformatf("v%0d out_instr", i), out_instr_a, word(vt[i].e_pc));
            end
        end
        start_a = 0; ready_a = 0;

        // LAST_ADDR = 31, start at 30: pc wraps to 0 while draining
        start_b = 1; sa_b = 30; ready_b = 1;
        @(posedge clk); #1;
        start_b = 0;
        chk("b start busy", 32'(busy_b), 1);
        chk("b start mem", 32'(mem_addr_b), 30);
        chk("b start valid", 32'(out_valid_b), 0);
        @(posedge clk); #1;
        chk("b pc30 valid", 32'(out_valid_b), 1);
        chk("b pc30 out_pc", 32'(out_pc_b), 30);
        chk("b pc30 instr", out_instr_b, word(5'd30));
        chk("b pc30 mem", 32'(mem_addr_b), 31);
        @(posedge clk); #1;
        chk("b pc31 out_pc", 32'(out_pc_b), 31);
        chk("b pc31 instr", out_instr_b, word(5'd31));
        chk("b wrap mem", 32'(mem_addr_b), 0);
        chk("b drain busy", 32'(busy_b), 1);
        @(posedge clk); #1;
        chk("b done", 32'(done_b), 1);
        chk("b done valid", 32'(out_valid_b), 0);
        chk("b done busy", 32'(busy_b), 0);
        @(posedge clk); #1;
        chk("b done pulse", 32'(done_b), 0);

        // Asynchronous reset in the middle of RUN with a word pending
        start_b = 1; sa_b = 5; ready_b = 0;
        @(posedge clk); #1;
        start_b = 0;
        @(posedge clk); #1;
        chk("b pre-rst valid", 32'(out_valid_b), 1);
        chk("b pre-rst out_pc", 32'(out_pc_b), 5);
        #2 rst_n_b = 1'b0;
        #1;
        chk("b arst valid", 32'(out_valid_b), 0);
        chk("b arst busy", 32'(busy_b), 0);
        chk("b arst mem", 32'(mem_addr_b), 0);
        chk("b arst out_pc", 32'(out_pc_b), 0);
        chk("b arst instr", out_instr_b, 0);
        chk("b arst done", 32'(done_b), 0);
        start_b = 1; sa_b = 7;
        @(negedge clk);
        rst_n_b = 1'b1;
        #1;
        chk("b rel no change", 32'(busy_b), 0);
        @(posedge clk); #1;
        chk("b rel start busy", 32'(busy_b), 1);
        chk("b rel start mem", 32'(mem_addr_b), 7);
        start_b = 0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
